// File: rtl/dtg_pkg.sv
// Shared timing constants and types for the 1024x768@60Hz display timing generator.
package dtg_pkg;
  localparam int H_ACTIVE = 1024;
  localparam int H_FP     = 24;
  localparam int H_SYNC   = 136;
  localparam int H_BP     = 160;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 768;
  localparam int V_FP     = 3;
  localparam int V_SYNC   = 6;
  localparam int V_BP     = 29;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic SYNC_POL = 1'b0;

  localparam logic [11:0] OFFSCREEN = 12'hFFF;

  typedef logic [7:0] bot_reg_t;
endpackage

// File: rtl/dtg_axis_counter.sv
// One raster axis: wrapping counter with active-area and sync-window decode.
module dtg_axis_counter #(
  parameter int W          = 11,
  parameter int TOTAL      = 1344,
  parameter int ACTIVE     = 1024,
  parameter int SYNC_START = 1048,
  parameter int SYNC_LEN   = 136
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o,
  output logic         active_o,
  output logic         sync_o
);
  localparam logic [W-1:0] LAST  = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT   = W'(ACTIVE);
  localparam logic [W-1:0] SS    = W'(SYNC_START);
  localparam logic [W-1:0] SE    = W'(SYNC_START + SYNC_LEN);

  logic [W-1:0] cnt_q, cnt_d;
  logic         last;

  assign last = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = last ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o    = cnt_q;
  assign wrap_o   = en_i & last;
  assign active_o = (cnt_q < ACT);
  // Raw sync window, active-high; polarity is applied by the output register.
  assign sync_o   = (cnt_q >= SS) && (cnt_q < SE);
endmodule

// File: rtl/display_timing_gen.sv
// Raster timing generator with frame-boundary rojobot snapshot.
// FRAME_LATCH_EN: loc*/botInfo outputs load only at the first blanking line; otherwise 1-cycle passthrough.
module display_timing_gen
  import dtg_pkg::*;
#(
  parameter int   HA  = H_ACTIVE,
  parameter int   HFP = H_FP,
  parameter int   HSW = H_SYNC,
  parameter int   HBP = H_BP,
  parameter int   VA  = V_ACTIVE,
  parameter int   VFP = V_FP,
  parameter int   VSW = V_SYNC,
  parameter int   VBP = V_BP,
  parameter logic POL = SYNC_POL
) (
  input  logic        clk,
  input  logic        reset,
  output logic        horiz_sync,
  output logic        vert_sync,
  output logic        video_on,
  output logic [11:0] pixel_row,
  output logic [11:0] pixel_column,
  output logic        frame_start,
  input  bot_reg_t    locX_in,
  input  bot_reg_t    locY_in,
  input  bot_reg_t    botInfo_in,
  output bot_reg_t    locX_out,
  output bot_reg_t    locY_out,
  output bot_reg_t    botInfo_out
);
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;

  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        h_wrap, h_act, h_sync, v_act, v_sync, v_wrap_unused;
  logic        snap;

  dtg_axis_counter #(.W(11), .TOTAL(HT), .ACTIVE(HA), .SYNC_START(HA + HFP), .SYNC_LEN(HSW)) u_h (
    .clk(clk), .rst(reset), .en_i(1'b1), .cnt_o(h_cnt), .wrap_o(h_wrap),
    .active_o(h_act), .sync_o(h_sync)
  );

  dtg_axis_counter #(.W(10), .TOTAL(VT), .ACTIVE(VA), .SYNC_START(VA + VFP), .SYNC_LEN(VSW)) u_v (
    .clk(clk), .rst(reset), .en_i(h_wrap), .cnt_o(v_cnt), .wrap_o(v_wrap_unused),
    .active_o(v_act), .sync_o(v_sync)
  );

  logic        hs_q, hs_d, vs_q, vs_d, von_q, von_d, fs_q, fs_d;
  logic [11:0] row_q, row_d, col_q, col_d;
  bot_reg_t    lx_q, lx_d, ly_q, ly_d, bi_q, bi_d;

  // First clock of vertical blanking: the icon then holds these for the whole next frame.
  assign snap = (h_cnt == '0) && (v_cnt == 10'(VA));

  always_comb begin
    hs_d  = h_sync ? POL : ~POL;
    vs_d  = v_sync ? POL : ~POL;
    von_d = h_act & v_act;
    row_d = von_d ? {2'b00, v_cnt} : OFFSCREEN;
    col_d = von_d ? {1'b0, h_cnt}  : OFFSCREEN;
    fs_d  = (h_cnt == '0) && (v_cnt == '0);
`ifdef FRAME_LATCH_EN
    lx_d  = snap ? locX_in    : lx_q;
    ly_d  = snap ? locY_in    : ly_q;
    bi_d  = snap ? botInfo_in : bi_q;
`else
    lx_d  = locX_in;
    ly_d  = locY_in;
    bi_d  = botInfo_in;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q  <= ~POL;
      vs_q  <= ~POL;
      von_q <= 1'b0;
      row_q <= OFFSCREEN;
      col_q <= OFFSCREEN;
      fs_q  <= 1'b0;
      lx_q  <= '0;
      ly_q  <= '0;
      bi_q  <= '0;
    end else begin
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      von_q <= von_d;
      row_q <= row_d;
      col_q <= col_d;
      fs_q  <= fs_d;
      lx_q  <= lx_d;
      ly_q  <= ly_d;
      bi_q  <= bi_d;
    end
  end

  assign horiz_sync   = hs_q;
  assign vert_sync    = vs_q;
  assign video_on     = von_q;
  assign pixel_row    = row_q;
  assign pixel_column = col_q;
  assign frame_start  = fs_q;
  assign locX_out     = lx_q;
  assign locY_out     = ly_q;
  assign botInfo_out  = bi_q;
endmodule
